// File: rtl/trng_ctrl_if.sv
// rtl/trng_ctrl_if.sv - word output handshake between trng_ctrl and its consumer
interface trng_ctrl_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             data_ready;

   modport master (output data_out, output data_valid, input data_ready);
   modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/trng_ctrl.sv
// rtl/trng_ctrl.sv - ring-oscillator TRNG sequencer: sync, divided sampling,
// von Neumann debiasing, repetition-count health test and word packing
module trng_ctrl #(
   parameter int WIDTH      = 8,
   parameter int SAMPLE_DIV = 16,
   parameter int RCT_LIMIT  = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        rnd_raw,
   output logic        ro_en,
   output logic        health_fail,
   trng_ctrl_if.master dout
);
   localparam int DIV_W = $clog2(SAMPLE_DIV);
   localparam int BIT_W = $clog2(WIDTH);
   localparam int REP_W = $clog2(RCT_LIMIT + 1);

   typedef enum logic [2:0] {
      IDLE,
      WARMUP,
      COLLECT,
      HOLD,
      FAIL
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic               sync_q1;
   logic               s_bit;
   logic [1:0]         warm_cnt;
   logic [DIV_W-1:0]   div_cnt;
   logic               sample_stb;
   logic               phase;
   logic               first;
   logic [BIT_W-1:0]   bit_cnt;
   logic               pair_ok;
   logic               word_done;
   logic               prev_bit;
   logic [REP_W-1:0]   rep_cnt;
   logic [REP_W-1:0]   rep_nxt;
   logic               rct_trip;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q1 <= 1'b0;
         s_bit   <= 1'b0;
      end else begin
         sync_q1 <= rnd_raw;
         s_bit   <= sync_q1;
      end
   end

   always_comb begin
      sample_stb = (state == COLLECT) && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
      pair_ok    = sample_stb && phase && (first != s_bit);
      word_done  = pair_ok && (bit_cnt == BIT_W'(WIDTH - 1));
      // an all-zero history counts as a previous 0, so the first sample starts a run of 1
      if (s_bit != prev_bit) begin
         rep_nxt = REP_W'(1);
      end else if (rep_cnt == REP_W'(RCT_LIMIT)) begin
         rep_nxt = rep_cnt;
      end else begin
         rep_nxt = rep_cnt + REP_W'(1);
      end
      rct_trip = sample_stb && (rep_nxt == REP_W'(RCT_LIMIT));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      ro_en           = 1'b0;
      dout.data_valid = 1'b0;
      health_fail     = 1'b0;
      case (state)
         IDLE: begin
            if (en) state_nxt = WARMUP;
         end
         WARMUP: begin
            ro_en = 1'b1;
            if (!en) begin
               state_nxt = IDLE;
            end else if (warm_cnt == 2'd3) begin
               state_nxt = COLLECT;
            end
         end
         COLLECT: begin
            ro_en = 1'b1;
            // a tripped health test wins over a word finishing on the same sample
            if (rct_trip) begin
               state_nxt = FAIL;
            end else if (!en) begin
               state_nxt = IDLE;
            end else if (word_done) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            ro_en           = 1'b1;
            dout.data_valid = 1'b1;
            if (!en) begin
               state_nxt = IDLE;
            end else if (dout.data_ready) begin
               state_nxt = COLLECT;
            end
         end
         FAIL: begin
            health_fail = 1'b1;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         warm_cnt      <= 2'd0;
         div_cnt       <= '0;
         phase         <= 1'b0;
         first         <= 1'b0;
         bit_cnt       <= '0;
         prev_bit      <= 1'b0;
         rep_cnt       <= '0;
         dout.data_out <= '0;
      end else begin
         warm_cnt <= (state == WARMUP) ? warm_cnt + 2'd1 : 2'd0;

         // divider, pair phase and bit count restart on every entry to COLLECT
         if (state != COLLECT) begin
            div_cnt <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
         end else begin
            div_cnt <= sample_stb ? '0 : div_cnt + DIV_W'(1);
            if (sample_stb) begin
               phase <= ~phase;
               if (!phase) first <= s_bit;
               if (pair_ok) begin
                  bit_cnt       <= bit_cnt + BIT_W'(1);
                  dout.data_out <= {dout.data_out[WIDTH-2:0], first};
               end
            end
         end

         // run history survives HOLD so a stuck source cannot hide behind slow consumers
         if (state == IDLE) begin
            prev_bit <= 1'b0;
            rep_cnt  <= '0;
         end else if (sample_stb) begin
            prev_bit <= s_bit;
            rep_cnt  <= rep_nxt;
         end
      end
   end
endmodule
